// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl
// Sequencer for the dual-channel SPI ADC reader. It requests a conversion
// on every sample tick (one every SAMPLE_DIV clocks), accumulates
// 2^AVG_LOG2 conversions per batch on both channels and publishes the
// truncated averages with a one-cycle valid strobe. It runs single-shot
// (start_i pulse) or continuously (cont_i level), and raises sticky flags
// for conversion timeouts and sample-rate overruns.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start_i             single-shot batch request, ignored while busy
//   cont_i              continuous mode, batches repeat while high
//   clr_err_i           clears timeout_o / overrun_o
//   busy_o              high whenever the sequencer is not idle
//   adc_en_o            registered conversion enable to the ADC reader
//   adc_update_i        ADC reader new-data strobe
//   adc_data0_i/1_i     12-bit channel samples
//   avg0_o/avg1_o       batch averages, held until the next batch
//   avg_valid_o         one-cycle strobe when the averages update
//   timeout_o           sticky: a conversion timed out
//   overrun_o           sticky: a tick arrived while a conversion was pending
module adc_scan_ctrl #(
  parameter int unsigned SAMPLE_DIV = 100000,
  parameter int unsigned AVG_LOG2   = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        cont_i,
  input  logic        clr_err_i,
  output logic        busy_o,
  output logic        adc_en_o,
  input  logic        adc_update_i,
  input  logic [11:0] adc_data0_i,
  input  logic [11:0] adc_data1_i,
  output logic [11:0] avg0_o,
  output logic [11:0] avg1_o,
  output logic        avg_valid_o,
  output logic        timeout_o,
  output logic        overrun_o
);

  localparam int unsigned TIMER_W = $clog2(SAMPLE_DIV);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W   = AVG_LOG2 + 1;
  localparam int unsigned ACC_W   = 12 + AVG_LOG2;

  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(2 ** AVG_LOG2);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT    = 2'd1;
  localparam logic [1:0] ST_CONVERT = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TO_W-1:0]    tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc0_q, acc0_d;
  logic [ACC_W-1:0]   acc1_q, acc1_d;
  logic               en_q, en_d;
  logic [11:0]        avg0_q, avg0_d;
  logic [11:0]        avg1_q, avg1_d;
  logic               valid_q, valid_d;
  logic               timeout_q, timeout_d;
  logic               overrun_q, overrun_d;

  logic               tick;
  logic [CNT_W-1:0]   cnt_inc;

  // The timer sits at zero while idle, so leaving IDLE always starts it
  // from zero; once running it free-wraps and is never re-aligned to the
  // conversions, which keeps the sample rate exact in continuous mode.
  always_comb begin
    tick    = (state_q != ST_IDLE) && (timer_q == TIMER_MAX);
    cnt_inc = cnt_q + CNT_W'(1);
    if (state_q == ST_IDLE) begin
      timer_d = '0;
    end else if (timer_q == TIMER_MAX) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TIMER_W'(1);
    end
  end

  // Sequencer next-state logic. Error events are evaluated after the
  // clear request so that a coincident error keeps its flag set.
  always_comb begin
    state_d   = state_q;
    tcnt_d    = tcnt_q;
    cnt_d     = cnt_q;
    acc0_d    = acc0_q;
    acc1_d    = acc1_q;
    en_d      = en_q;
    avg0_d    = avg0_q;
    avg1_d    = avg1_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    overrun_d = overrun_q;

    if (clr_err_i) begin
      timeout_d = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i || cont_i) begin
          state_d = ST_WAIT;
          acc0_d  = '0;
          acc1_d  = '0;
          cnt_d   = '0;
        end
      end

      ST_WAIT: begin
        if (tick) begin
          state_d = ST_CONVERT;
          en_d    = 1'b1;
          tcnt_d  = '0;
        end
      end

      ST_CONVERT: begin
        if (adc_update_i) begin
          // An update always wins over a coincident timeout or tick.
          en_d    = 1'b0;
          acc0_d  = acc0_q + ACC_W'(adc_data0_i);
          acc1_d  = acc1_q + ACC_W'(adc_data1_i);
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CNT_FULL) ? ST_DONE : ST_WAIT;
        end else begin
          if (tick) begin
            overrun_d = 1'b1;
          end
          if (tcnt_q == TO_MAX) begin
            // The whole batch is abandoned; continuous mode re-enters
            // from IDLE on its own because cont_i is still sampled there.
            en_d      = 1'b0;
            timeout_d = 1'b1;
            acc0_d    = '0;
            acc1_d    = '0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
      end

      default: begin
        // ST_DONE: the averages and the strobe are registered together
        // so the strobe is high exactly while the new values first appear.
        avg0_d  = 12'(acc0_q >> AVG_LOG2);
        avg1_d  = 12'(acc1_q >> AVG_LOG2);
        valid_d = 1'b1;
        acc0_d  = '0;
        acc1_d  = '0;
        cnt_d   = '0;
        state_d = cont_i ? ST_WAIT : ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      tcnt_q    <= '0;
      cnt_q     <= '0;
      acc0_q    <= '0;
      acc1_q    <= '0;
      en_q      <= 1'b0;
      avg0_q    <= '0;
      avg1_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      tcnt_q    <= tcnt_d;
      cnt_q     <= cnt_d;
      acc0_q    <= acc0_d;
      acc1_q    <= acc1_d;
      en_q      <= en_d;
      avg0_q    <= avg0_d;
      avg1_q    <= avg1_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign adc_en_o    = en_q;
  assign avg0_o      = avg0_q;
  assign avg1_o      = avg1_q;
  assign avg_valid_o = valid_q;
  assign timeout_o   = timeout_q;
  assign overrun_o   = overrun_q;

endmodule
